mem_responder: RTL and testbench



---
 rtl/mem_responder.sv | 70 +++++++
 tb/tb_mem_responder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: word-addressed 16-bit memory answering the Enable/RW/MFC handshake after a programmable wait
module mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Enable,
  input  logic              RW,
  input  logic [15:0]       addr,
  input  logic [15:0]       data_in,
  output logic [15:0]       data_out,
  output logic              MFC,
  output logic              err,
  output logic              busy,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [15:0]       load_data
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state;
  logic [15:0] mem [2**ADDR_W];
  logic [15:0] a_lat, d_lat;
  logic rw_lat;
  logic [3:0] cnt;
  logic in_range, ld_wr, acc_wr;
  logic [ADDR_W-1:0] idx;
  assign idx = a_lat[ADDR_W-1:0];
  assign in_range = (a_lat >> ADDR_W) == 16'h0;
  assign busy = state != IDLE;
  assign ld_wr = state == IDLE && load_en;
  assign acc_wr = state == WAIT && Enable && cnt == 4'd0 && !rw_lat && in_range;
  always_ff @(posedge clk)
    if (!reset && (ld_wr || acc_wr))
      mem[ld_wr ? load_addr : idx] <= ld_wr ? load_data : d_lat;
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      MFC <= 1'b0;
      err <= 1'b0;
      data_out <= 16'h0;
      cnt <= 4'd0;
    end else
      case (state)
        IDLE:
          if (!load_en && Enable) begin
            a_lat <= addr;
            rw_lat <= RW;
            d_lat <= data_in;
            cnt <= 4'(WAIT_CYCLES);
            state <= WAIT;
          end
        WAIT:
          if (!Enable) state <= IDLE;
          else if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else begin
            state <= DONE;
            MFC <= 1'b1;
            err <= !in_range;
            if (rw_lat) data_out <= in_range ? mem[idx] : 16'h0;
          end
        DONE:
          if (!Enable) begin
            state <= IDLE;
            MFC <= 1'b0;
            err <= 1'b0;
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench driving a WAIT_CYCLES=2 and a WAIT_CYCLES=0 responder against a memory model
module tb_mem_responder;
  typedef struct {logic [15:0] d; logic e; int c;} exp_t;
  logic clk = 0;
  always #5 clk = ~clk;
  logic [1:0] rst, en, rw, le, mfc, er, bsy;
  logic [15:0] ad [2];
  logic [15:0] di [2];
  logic [15:0] ld [2];
  logic [15:0] dout [2];
  logic [7:0] la [2];
  int cyc = 0, vec = 0, miss = 0;
  exp_t q [2][$];
  logic [15:0] model [2][256];
  logic [15:0] last [2];
  always @(posedge clk) cyc <= cyc + 1;
  mem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .reset(rst[0]), .Enable(en[0]), .RW(rw[0]), .addr(ad[0]), .data_in(di[0]),
    .data_out(dout[0]), .MFC(mfc[0]), .err(er[0]), .busy(bsy[0]),
    .load_en(le[0]), .load_addr(la[0]), .load_data(ld[0]));
  mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(rst[1]), .Enable(en[1]), .RW(rw[1]), .addr(ad[1]), .data_in(di[1]),
    .data_out(dout[1]), .MFC(mfc[1]), .err(er[1]), .busy(bsy[1]),
    .load_en(le[1]), .load_addr(la[1]), .load_data(ld[1]));
  function automatic int wc(int i);
    return i == 0 ? 2 : 0;
  endfunction
  task automatic chk(string n, int i, logic [31:0] act, logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s inst%0d: got %0h expected %0h", n, i, act, exp);
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : g_mon
    logic pm = 1'b0;
    exp_t x;
    always @(negedge clk) begin
      if (mfc[g] && !pm) begin
        if (q[g].size() == 0) chk("spurious_mfc", g, mfc[g], 0);
        else begin
          x = q[g].pop_front();
          chk("data_out", g, dout[g], x.d);
          chk("err", g, er[g], x.e);
          chk("latency", g, cyc, x.c);
        end
      end
      pm = mfc[g];
    end
  end
  task automatic load(int i, logic [7:0] a, logic [15:0] d);
    @(negedge clk);
    le[i] = 1'b1; la[i] = a; ld[i] = d;
    model[i][a] = d;
    @(negedge clk);
    le[i] = 1'b0;
  endtask
  task automatic access(int i, logic r, logic [15:0] a, logic [15:0] d, bit coll, logic [7:0] cla,
                        logic [15:0] cld, bit rdone);
    exp_t x;
    int t;
    @(negedge clk);
    en[i] = 1'b1; rw[i] = r; ad[i] = a; di[i] = d; le[i] = coll; la[i] = cla; ld[i] = cld;
    if (coll) model[i][cla] = cld;
    x.c = cyc + 2 + wc(i) + (coll ? 1 : 0);
    x.e = (a >> 8) != 16'h0;
    if (!x.e && r) last[i] = model[i][a[7:0]];
    else if (!x.e) model[i][a[7:0]] = d;
    else if (r) last[i] = 16'h0;
    x.d = last[i];
    q[i].push_back(x);
    @(negedge clk);
    le[i] = 1'b0;
    if (coll) @(negedge clk);
    rw[i] = 1'($urandom); ad[i] = 16'($urandom); di[i] = 16'($urandom);
    t = 0;
    while (!mfc[i] && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("mfc_rise", i, mfc[i], 1);
    if (rdone) begin
      rst[i] = 1'b1;
      @(negedge clk);
      rst[i] = 1'b0; en[i] = 1'b0; last[i] = 16'h0;
      chk("rst_mfc", i, mfc[i], 0);
      chk("rst_busy", i, bsy[i], 0);
      chk("rst_err", i, er[i], 0);
      chk("rst_dout", i, dout[i], 0);
      @(negedge clk);
    end else begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      chk("mfc_hold", i, mfc[i], 1);
      en[i] = 1'b0;
      @(negedge clk);
      chk("mfc_drop", i, mfc[i], 0);
      chk("busy_idle", i, bsy[i], 0);
      chk("dout_hold", i, dout[i], last[i]);
    end
  endtask
  task automatic abort(int i, logic [15:0] a, logic [15:0] d, int j);
    @(negedge clk);
    en[i] = 1'b1; rw[i] = 1'b0; ad[i] = a; di[i] = d;
    @(negedge clk);
    chk("wait_busy", i, bsy[i], 1);
    repeat (j - 1) @(negedge clk);
    en[i] = 1'b0;
    @(negedge clk);
    chk("abort_busy", i, bsy[i], 0);
    chk("abort_mfc", i, mfc[i], 0);
  endtask
  task automatic rst_wait(int i, logic [15:0] a, logic [15:0] d);
    @(negedge clk);
    en[i] = 1'b1; rw[i] = 1'b0; ad[i] = a; di[i] = d;
    @(negedge clk);
    rst[i] = 1'b1;
    @(negedge clk);
    rst[i] = 1'b0; en[i] = 1'b0; last[i] = 16'h0;
    chk("rstw_busy", i, bsy[i], 0);
    chk("rstw_mfc", i, mfc[i], 0);
  endtask
  initial begin
    int i, op;
    logic [15:0] a, d;
    logic [7:0] b;
    rst = 2'b11; en = 2'b00; rw = 2'b00; le = 2'b00;
    for (int k = 0; k < 2; k++) begin
      ad[k] = 16'h0; di[k] = 16'h0; ld[k] = 16'h0; la[k] = 8'h0; last[k] = 16'h0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_dout", k, dout[k], 0);
      chk("reset_mfc", k, mfc[k], 0);
      chk("reset_err", k, er[k], 0);
      chk("reset_busy", k, bsy[k], 0);
    end
    rst = 2'b00;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      le = 2'b11;
      for (int m = 0; m < 2; m++) begin
        la[m] = 8'(k);
        ld[m] = 16'($urandom);
        model[m][k] = ld[m];
      end
    end
    @(negedge clk);
    le = 2'b00;
    load(0, 8'h10, 16'hBEEF);
    access(0, 1, 16'h0010, 16'h0, 0, 8'h0, 16'h0, 0);
    access(0, 0, 16'h0005, 16'h1234, 0, 8'h0, 16'h0, 0);
    access(0, 1, 16'h0005, 16'h0, 0, 8'h0, 16'h0, 0);
    access(0, 1, 16'h0100, 16'h0, 0, 8'h0, 16'h0, 0);
    access(0, 0, 16'h0105, 16'hFFFF, 0, 8'h0, 16'h0, 0);
    access(0, 1, 16'h0005, 16'h0, 0, 8'h0, 16'h0, 0);
    load(0, 8'h07, 16'hAAAA);
    abort(0, 16'h0007, 16'h5555, 2);
    access(0, 1, 16'h0007, 16'h0, 0, 8'h0, 16'h0, 0);
    access(0, 1, 16'h0010, 16'h0, 0, 8'h0, 16'h0, 1);
    rst_wait(0, 16'h0010, 16'h0000);
    access(0, 1, 16'h0010, 16'h0, 0, 8'h0, 16'h0, 0);
    access(0, 1, 16'h0020, 16'h0, 1, 8'h20, 16'h7777, 0);
    access(1, 1, 16'h0005, 16'h0, 1, 8'h05, 16'h6666, 0);
    access(1, 0, 16'h0009, 16'h4321, 0, 8'h0, 16'h0, 0);
    access(1, 1, 16'h0009, 16'h0, 0, 8'h0, 16'h0, 0);
    for (int n = 0; n < 300; n++) begin
      i = n % 2;
      op = $urandom_range(0, 9);
      a = {8'h0, 8'($urandom)};
      d = 16'($urandom);
      b = $urandom_range(0, 1) ? a[7:0] : 8'($urandom);
      if (op <= 3) access(i, 1, a, d, 0, 8'h0, 16'h0, 0);
      else if (op <= 5) access(i, 0, a, d, 0, 8'h0, 16'h0, 0);
      else if (op == 6) access(i, 1'($urandom), 16'($urandom_range(256, 65535)), d, 0, 8'h0, 16'h0, 0);
      else if (op == 7) abort(i, a, d, $urandom_range(1, wc(i) + 1));
      else if (op == 8) access(i, 1'($urandom), a, d, 1, b, 16'($urandom), 0);
      else if ($urandom_range(0, 3) == 0) rst_wait(i, a, d);
      else access(i, 1, a, d, 0, 8'h0, 16'h0, $urandom_range(0, 1) == 1);
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) chk("sb_empty", k, q[k].size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
